// File: rtl/wave_pkg.sv
// Shared types and constants for the wave status transmitter.
// Serializer state encoding and status ASCII characters.
package wave_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;

   localparam logic [7:0] CH_Q = 8'h51;
   localparam logic [7:0] CH_T = 8'h54;
   localparam logic [7:0] CH_S = 8'h53;
   localparam logic [7:0] CH_I = 8'h49;
   localparam logic [7:0] CH_UNK = 8'h3F;
   localparam logic [7:0] CH_N = 8'h4E;
   localparam logic [7:0] CH_F = 8'h46;

   function automatic logic [7:0] wave_char(
      input logic [2:0] code
   );
      logic [7:0] c;
      case (code)
         3'd0: c = CH_Q;
         3'd1: c = CH_T;
         3'd2: c = CH_S;
         3'd3: c = CH_I;
         default: c = CH_UNK;
      endcase
      return c;
   endfunction

   function automatic logic [7:0] noise_char(
      input logic en
   );
      return en ? CH_N : CH_F;
   endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART serializer: FSM plus baud counter, pops bytes from a FIFO.
// Ports: clk, rst_n, fifo_empty, fifo_data in; pop, tx, busy out.
module uart_tx_core
   import wave_pkg::*;
#(
   parameter int CLKS_PER_BIT = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       pop,
   output logic       tx,
   output logic       busy
);

   localparam int BW =
      (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t     state;
   logic [BW-1:0] baud;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          bit_end;

   assign bit_end = (baud == LAST);
   assign busy    = (state != ST_IDLE);

   // Pop in IDLE, or at the end of a stop bit to chain frames.
   assign pop = !fifo_empty &&
                ((state == ST_IDLE) ||
                 (state == ST_STOP && bit_end));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else begin
         if (state == ST_IDLE || bit_end)
            baud <= '0;
         else
            baud <= baud + 1'b1;
         case (state)
            ST_IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  state <= ST_START;
                  shreg <= fifo_data;
                  tx    <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
                  tx      <= shreg[0];
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bit_cnt == 3'd7) begin
                     state <= ST_STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx      <= shreg[1];
                  end
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (pop) begin
                     state <= ST_START;
                     shreg <= fifo_data;
                     tx    <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/wave_status_tx.sv
// Byte FIFO + UART TX, with optional waveform status reporter.
// Ports: clk, rst_n, wave_select, white_noise_en, in_data/in_valid/
// in_ready host stream, tx serial line, tx_busy.
// Reporter built only when WAVE_STATUS_REPORT_EN is defined.
module wave_status_tx
   import wave_pkg::*;
#(
   parameter int CLKS_PER_BIT = 2604,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] wave_select,
   input  logic       white_noise_en,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       tx_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] TWO_FREE = (AW+1)'(FIFO_DEPTH - 2);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] wr_nxt;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   push_n;
   logic          live;
   logic          fifo_empty;
   logic          fifo_full;
   logic          host_push;
   logic          st_push;
   logic          pop;
   logic          core_busy;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_CNT);
   assign wr_nxt     = wr_ptr + 1'b1;

`ifdef WAVE_STATUS_REPORT_EN
   logic [2:0] ws_q;
   logic       ne_q;
   logic       pending;
   logic       change;
   logic       req;

   // The detect cycle itself can push, so a report always beats
   // a host byte offered in the same cycle. Values are taken at
   // push time, which collapses any burst of changes.
   assign change  = live &&
                    ((wave_select != ws_q) ||
                     (white_noise_en != ne_q));
   assign req     = pending || change;
   assign st_push = req && (count <= TWO_FREE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ws_q    <= '0;
         ne_q    <= 1'b0;
         pending <= 1'b0;
      end else begin
         ws_q    <= wave_select;
         ne_q    <= white_noise_en;
         pending <= req && !st_push;
      end
   end
`else
   logic unused_status;
   assign unused_status = ^{wave_select, white_noise_en};
   assign st_push = 1'b0;
`endif

   assign in_ready  = live && !fifo_full && !st_push;
   assign host_push = in_valid && in_ready;

   always_comb begin
      push_n = '0;
      if (st_push)
         push_n = (AW+1)'(2);
      else if (host_push)
         push_n = (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live   <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         live   <= 1'b1;
         count  <= count + push_n - (AW+1)'(pop);
         wr_ptr <= wr_ptr + push_n[AW-1:0];
         rd_ptr <= rd_ptr + AW'(pop);
`ifdef WAVE_STATUS_REPORT_EN
         if (st_push) begin
            mem[wr_ptr] <= wave_char(wave_select);
            mem[wr_nxt] <= noise_char(white_noise_en);
         end else
`endif
         if (host_push)
            mem[wr_ptr] <= in_data;
      end
   end

   uart_tx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .fifo_empty(fifo_empty),
      .fifo_data (mem[rd_ptr]),
      .pop       (pop),
      .tx        (tx),
      .busy      (core_busy)
   );

   assign tx_busy = core_busy || !fifo_empty;

endmodule
